// File: rtl/div32_seq.sv
// Multi-cycle 32-bit restoring divider: quotient on LoResult, remainder on HiResult.
// Signed ops divide magnitudes and then fix up the signs in a final cycle.
module div32_seq (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] LoResult,
    output logic [31:0] HiResult,
    output logic        DivByZero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t      state;
    logic        sgn_op;
    logic        a_neg;
    logic        b_neg;
    logic        dz;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] a_lat;
    logic [4:0]  cnt;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] rem_sh;
    logic        sub_ok;
    logic [31:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign dbg_state = state;

    always_comb begin
        a_abs  = (Signed && A[31]) ? (32'd0 - A) : A;
        b_abs  = (Signed && B[31]) ? (32'd0 - B) : B;
        rem_sh = {rem, dvd[31]};
        sub_ok = (rem_sh >= {1'b0, dvs});
        // When the subtract succeeds the difference is below dvs, so 32 bits suffice.
        diff   = rem_sh[31:0] - dvs;
        q_fix  = (sgn_op && (a_neg ^ b_neg)) ? (32'd0 - dvd) : dvd;
        r_fix  = (sgn_op && a_neg) ? (32'd0 - rem) : rem;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            sgn_op    <= 1'b0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            dz        <= 1'b0;
            dvd       <= 32'd0;
            dvs       <= 32'd0;
            rem       <= 32'd0;
            a_lat     <= 32'd0;
            cnt       <= 5'd0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            LoResult  <= 32'd0;
            HiResult  <= 32'd0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        sgn_op <= Signed;
                        a_neg  <= A[31];
                        b_neg  <= B[31];
                        dvd    <= a_abs;
                        dvs    <= b_abs;
                        rem    <= 32'd0;
                        cnt    <= 5'd0;
                        a_lat  <= A;
                        dz     <= (B == 32'd0);
                        Busy   <= 1'b1;
                        state  <= (B == 32'd0) ? FIXUP : RUN;
                    end
                end
                RUN: begin
                    // Quotient bits shift into dvd as dividend bits shift out.
                    if (sub_ok) begin
                        rem <= diff;
                        dvd <= {dvd[30:0], 1'b1};
                    end else begin
                        rem <= rem_sh[31:0];
                        dvd <= {dvd[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (dz) begin
                        LoResult <= 32'hFFFF_FFFF;
                        HiResult <= a_lat;
                    end else begin
                        LoResult <= q_fix;
                        HiResult <= r_fix;
                    end
                    DivByZero <= dz;
                    Done      <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/div32_seq.md
# div32_seq

Multi-cycle 32-bit integer divider, the inverse of the datapath's single-cycle multiply path. It accepts a dividend/divisor pair with a start pulse and iterates one restoring-division step per clock. It returns quotient on LoResult and remainder on HiResult, the same Hi/Lo split the multiply ops use, so the Hi/Lo register write-back logic consumes both units identically. It sits beside the ALU in the EX stage, and the hazard unit stalls on Busy.

## Interface
- No parameters; width fixed at 32.
- Clk  in  1  rising-edge clock, sole clock domain.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Signed  in  1  1 = signed divide (div), 0 = unsigned (divu); latched at Start.
- A  in  32  dividend; latched at Start.
- B  in  32  divisor; latched at Start.
- Busy  out  1  operation in progress; Start ignored while high.
- Done  out  1  one-cycle pulse; HiResult/LoResult/DivByZero valid from this cycle on.
- LoResult  out  32  quotient.
- HiResult  out  32  remainder.
- DivByZero  out  1  last completed op had B == 0.

## Operation
- States: IDLE, RUN, FIXUP.
- IDLE, Start=1:
  - Latch Signed and the operand signs.
  - Load the working dividend with |A| and the divisor with |B|. Absolute values are taken only if Signed=1; otherwise the raw operands are used.
  - Clear the partial remainder and the 5-bit counter.
  - If B == 0, go to FIXUP directly. Otherwise go to RUN.
- RUN, each cycle:
  - Shift {rem, dvd} left by 1 and trial-subtract the divisor from rem.
  - If the result is non-negative (33-bit compare), keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Counter increments. After the 32nd step (counter == 31), go to FIXUP.
- FIXUP, single cycle:
  - Signed: quotient is negated iff the operand signs differ; remainder is negated iff A was negative.
  - Register LoResult/HiResult, pulse Done, return to IDLE.
- Divide by zero: LoResult = 32'hFFFFFFFF, HiResult = A (as latched), DivByZero = 1. This applies for both Signed values.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LoResult = 0x80000000 and HiResult = 0, DivByZero = 0. This is the natural result of the abs/negate path and needs no special case.
- Unsigned 0x80000000 operands are not sign-treated.
- Results hold between operations. They change only at a FIXUP edge or on reset.
- DivByZero is rewritten at every completion.

## Timing
- Reset (Rst=0, asynchronous): state IDLE, counter 0, Busy 0, Done 0, LoResult 0, HiResult 0, DivByZero 0.
- Reset mid-operation aborts: no Done, outputs return to 0.
- Start accepted at edge k (nonzero B):
  - Busy = 1 after edges k through k+32.
  - RUN steps occur at edges k+1..k+32; FIXUP is the edge k+33.
  - After edge k+33: Busy = 0, Done = 1 for exactly one cycle, results valid.
- B == 0: FIXUP at edge k+1. Busy is high for 1 cycle, then Done.
- Busy and Done are never high together.
- Start while Busy: ignored, with no queueing.
- Start during the Done cycle: accepted, because state is IDLE. Back-to-back throughput is one op per 34 cycles.
- Changes on A/B/Signed after the Start edge have no effect on the op in flight.

## Test plan
- Unsigned A=100, B=7, Start at edge k -> Done high after edge k+33 only; LoResult=14, HiResult=2, DivByZero=0; Busy high 33 cycles.
- Signed A=-7 (0xFFFFFFF9), B=2 -> LoResult=0xFFFFFFFD, HiResult=0xFFFFFFFF. Signed A=7, B=-2 -> LoResult=0xFFFFFFFD, HiResult=1.
- Unsigned A=0xFFFFFFFF, B=0x10 -> LoResult=0x0FFFFFFF, HiResult=0xF. The same operands signed -> LoResult=0, HiResult=0xFFFFFFFF.
- A=5, B=0 (both Signed values) -> Done after edge k+1, LoResult=0xFFFFFFFF, HiResult=5, DivByZero=1. A following 9/3 clears DivByZero and gives Lo=3, Hi=0.
- Signed 0x80000000 / 0xFFFFFFFF -> LoResult=0x80000000, HiResult=0, DivByZero=0.
- Handshake/reset:
  - Start pulses mid-op are ignored and the result is unchanged.
  - Start in the Done cycle begins the next op; its Done arrives 34 cycles later.
  - Rst low at the 10th RUN cycle -> all outputs 0 asynchronously and no Done; the next op completes correctly.
